// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with req/ack memory
// handshakes, bounded wait timeout and a retired-instruction counter.
module instr_sequencer #(
    parameter logic [5:0] HALT_OPCODE = 6'b111111,
    parameter int         WAIT_MAX    = 15,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             mem_r,
    input  logic             mem_w,
    input  logic             reg_w,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_load,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_we,
    output logic             pc_we,
    output logic             busy,
    output logic             halted,
    output logic             timeout_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t            st;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_any;
    logic              wait_exp;

    assign mem_any  = mem_r | mem_w;
    assign wait_exp = (wait_cnt == WAIT_LIM);

    assign state    = st;
    assign imem_req = (st == S_FETCH);
    assign dmem_req = (st == S_MEM);
    assign dmem_we  = (st == S_MEM) & mem_w & ~mem_r;
    assign reg_we   = (st == S_WB);
    assign halted   = (st == S_HALT);
    assign busy     = (st == S_FETCH) | (st == S_DECODE) | (st == S_EXEC)
                    | (st == S_MEM) | (st == S_WB);

    assign ir_load  = (st == S_FETCH) & imem_ack;

    // Retire points: plain EXEC, store ack, and writeback.
    always_comb begin
        pc_we = 1'b0;
        unique case (1'b1)
            (st == S_EXEC): pc_we = ~mem_any & ~reg_w;
            (st == S_MEM):  pc_we = dmem_ack & ~mem_r;
            (st == S_WB):   pc_we = 1'b1;
            default:        pc_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= S_IDLE;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
            retired     <= '0;
        end else begin
            if (pc_we)
                retired <= retired + 1'b1;
            unique case (st)
                S_IDLE: begin
                    if (start) begin
                        st       <= S_FETCH;
                        wait_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        st <= S_DECODE;
                    end else if (wait_exp) begin
                        st          <= S_HALT;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    st <= (opcode == HALT_OPCODE) ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    wait_cnt <= '0;
                    if (mem_any)
                        st <= S_MEM;
                    else if (reg_w)
                        st <= S_WB;
                    else
                        st <= S_FETCH;
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        st       <= mem_r ? S_WB : S_FETCH;
                        wait_cnt <= '0;
                    end else if (wait_exp) begin
                        st          <= S_HALT;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WB: begin
                    st       <= S_FETCH;
                    wait_cnt <= '0;
                end
                S_HALT: st <= S_HALT;
                default: st <= S_HALT;
            endcase
        end
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle sequencer for the processor datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB and sequences the instruction memory, instruction register, data memory, register file write and PC update. Memory accesses use a req/ack handshake. A bounded wait counter halts the core if a memory does not respond. It sits between the combinational decoder (which supplies `mem_r`/`mem_w`/`reg_w`) and the datapath enables.

## Interface
- `HALT_OPCODE`, default 6'b111111: opcode that stops the core.
- `WAIT_MAX`, default 15: maximum number of cycles a memory request may go unacknowledged.
- `CNT_W`, default 16: width of the retired-instruction counter.

- `clk` in 1: the only clock.
- `rst` in 1: reset. Synchronous, active-high.
- `start` in 1: leaves IDLE to begin execution.
- `opcode` in 6: opcode field of the instruction register.
- `mem_r` in 1: decoded memory-read indicator.
- `mem_w` in 1: decoded memory-write indicator.
- `reg_w` in 1: decoded register-write indicator.
- `imem_ack` in 1: instruction memory acknowledge.
- `dmem_ack` in 1: data memory acknowledge.
- `imem_req` out 1: instruction memory request.
- `ir_load` out 1: instruction register load enable.
- `dmem_req` out 1: data memory request.
- `dmem_we` out 1: data memory write enable (qualifies `dmem_req`).
- `reg_we` out 1: gated register-file write enable.
- `pc_we` out 1: PC update enable.
- `busy` out 1: high in any state other than IDLE and HALT.
- `halted` out 1: high in HALT.
- `timeout_err` out 1: sticky flag set by a memory timeout.
- `state` out 3: current state encoding.
- `retired` out CNT_W: count of retired instructions.

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encoding 7 is illegal and goes to HALT on the next cycle.
- **IDLE:** if `start`=1, go to FETCH. Otherwise stay.
- **FETCH:**
  - `imem_req`=1.
  - On `imem_ack`: `ir_load`=1 in the same cycle, then go to DECODE.
- **DECODE:**
  - If `opcode`==HALT_OPCODE, go to HALT. The HALT instruction does not retire.
  - Otherwise go to EXEC.
- **EXEC:**
  - If `mem_r`|`mem_w`, go to MEM.
  - Else if `reg_w`, go to WB.
  - Else `pc_we`=1 and go to FETCH (branch, jump or no-op retire here).
- **MEM:**
  - `dmem_req`=1.
  - `dmem_we`=`mem_w` & ~`mem_r`. If both `mem_r` and `mem_w` are high, the access is a read.
  - On `dmem_ack`: if `mem_r`, go to WB. Otherwise `pc_we`=1 and go to FETCH.
- **WB:** `reg_we`=1 and `pc_we`=1, then go to FETCH.
- **HALT:**
  - `halted`=1.
  - `start` is ignored; only `rst` leaves HALT.
- **Wait counter** (4 bits for the default WAIT_MAX):
  - Clears on entry to FETCH or MEM.
  - Increments each cycle the state stays in FETCH or MEM without an ack.
  - If the counter equals WAIT_MAX and the ack is low, go to HALT and set `timeout_err`=1.
  - An ack in that same cycle wins: it is accepted normally and no error is raised.
- **`retired`:** increments by 1 on every cycle with `pc_we`=1. Wraps from 2^CNT_W−1 to 0.
- **`reg_we` gating:** asserted only in WB, so register-file writes happen only in WB.

## Timing
- All state, the wait counter, `retired` and `timeout_err` update on the rising edge of `clk`.
- Reset:
  - `rst`=1 at an edge forces state=IDLE and clears the counters and `timeout_err`.
  - This holds in any state, including mid-handshake. Any outstanding request is dropped with no further strobe.
- Output decoding:
  - Moore outputs, decoded from the state register: `imem_req`, `dmem_req`, `dmem_we`, `reg_we`, `busy`, `halted`, `state`.
  - Mealy outputs, combinational in the same cycle: `ir_load` (FETCH & `imem_ack`) and `pc_we`.
- Outputs after reset: every 1-bit output is 0, `state`=0 and `retired`=0.
- Latency with zero-wait memories (ack in the first request cycle):
  - ALU instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch or no-op: 3 cycles.
- Each cycle of memory wait adds 1 cycle.
- Handshake rules:
  - Requests stay high until the ack arrives or a timeout occurs.
  - An ack seen outside FETCH or MEM is ignored.
- Decode inputs are sampled in EXEC and MEM and must stay stable while the instruction register holds.

## Test plan
- **Reset then start, ALU instruction:** after reset, pulse `start`. Present `opcode`=0, `reg_w`=1, with `imem_ack` high in the first FETCH cycle. Required: states 1→2→3→5→1, one `reg_we` pulse, `retired`=1.
- **Load with 3 wait cycles:** `mem_r`=1, `dmem_ack` rises on the 4th MEM cycle. Required: `dmem_req` high for 4 cycles, `dmem_we`=0, WB follows, total latency 8 cycles.
- **Store:** `mem_w`=1, `reg_w`=0. Required: `dmem_we`=1 during MEM, `pc_we` pulses in the ack cycle, `reg_we` never rises.
- **Timeout boundary:**
  - Case 1: hold `imem_ack`=0. Required: HALT entered after WAIT_MAX+1 FETCH cycles, `timeout_err`=1 and `halted`=1.
  - Case 2: repeat with the ack arriving exactly on the final cycle. Required: normal DECODE, no error.
- **Halt instruction:** fetch `opcode`=6'b111111. Required: DECODE→HALT, `retired` unchanged, `start` pulses ignored. Then `rst`=1 mid-HALT. Required: IDLE with all outputs 0.
- **Counter wrap and mid-operation reset:**
  - Preload with CNT_W=4 and retire 16 instructions. Required: `retired` wraps to 0.
  - Assert `rst` during MEM with `dmem_req` high. Required: next cycle state=0 and `dmem_req`=0.
